// File: rtl/knn_scan_ctrl.sv
// Query capture, distance-unit scan and nearest-neighbour result streaming.
// Define KNN_DIST_STREAM_EN to also stream every per-point distance first.
module knn_scan_ctrl #(
  parameter int NUMBER_ELEMENTS = 6,
  parameter int DATA_WIDTH      = 32,
  parameter int CLASS_WIDTH     = 8,
  parameter int IDX_WIDTH       = 3
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   s_axis_tvalid,
  output logic                   s_axis_tready,
  input  logic [DATA_WIDTH-1:0]  s_axis_tdata,
  input  logic                   s_axis_tlast,
  output logic                   m_axis_tvalid,
  input  logic                   m_axis_tready,
  output logic [DATA_WIDTH-1:0]  m_axis_tdata,
  output logic                   m_axis_tlast,
  output logic [DATA_WIDTH-1:0]  query_x,
  output logic [DATA_WIDTH-1:0]  query_y,
  output logic                   dist_req_valid,
  input  logic                   dist_req_ready,
  output logic [IDX_WIDTH-1:0]   dist_req_idx,
  input  logic                   dist_rsp_valid,
  input  logic [IDX_WIDTH-1:0]   dist_rsp_idx,
  input  logic [DATA_WIDTH-1:0]  dist_rsp_data,
  input  logic [CLASS_WIDTH-1:0] dist_rsp_class,
  output logic                   busy,
  output logic                   err_frame
);

  typedef enum logic [2:0] {
    IDLE, GET_Y, ISSUE, DRAIN, SEND_D0, SEND_D1
`ifdef KNN_DIST_STREAM_EN
    , SEND_DIST
`endif
  } state_t;

  localparam logic [IDX_WIDTH-1:0] LAST_IDX =
    IDX_WIDTH'(NUMBER_ELEMENTS - 1);
  localparam logic [IDX_WIDTH:0] RSP_N =
    (IDX_WIDTH+1)'(NUMBER_ELEMENTS);

  state_t                 state, next;
  logic [IDX_WIDTH-1:0]   issue_cnt;
  logic [IDX_WIDTH:0]     rsp_cnt;
  logic [DATA_WIDTH-1:0]  best_dist;
  logic [IDX_WIDTH-1:0]   best_idx;
  logic [CLASS_WIDTH-1:0] best_class;
  logic [DATA_WIDTH-1:0]  res_word;
  logic                   s_hs, req_hs, rsp_ok;
  logic                   last_req, rsp_done;

`ifdef KNN_DIST_STREAM_EN
  logic [DATA_WIDTH-1:0] dist_buf [NUMBER_ELEMENTS];
`endif

  assign s_hs     = s_axis_tvalid & s_axis_tready;
  assign req_hs   = dist_req_valid & dist_req_ready;
  assign rsp_ok   = dist_rsp_valid &
                    (state == ISSUE || state == DRAIN);
  assign last_req = issue_cnt == LAST_IDX;
  assign rsp_done = rsp_cnt == RSP_N;
  assign dist_req_idx = issue_cnt;
  assign res_word = DATA_WIDTH'({best_idx, best_class});

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= next;
  end

  always_comb begin
    next           = state;
    s_axis_tready  = 1'b0;
    dist_req_valid = 1'b0;
    m_axis_tvalid  = 1'b0;
    m_axis_tdata   = '0;
    m_axis_tlast   = 1'b0;
    busy           = 1'b1;
    unique case (state)
      IDLE: begin
        busy          = 1'b0;
        s_axis_tready = 1'b1;
        if (s_axis_tvalid && !s_axis_tlast) next = GET_Y;
      end
      GET_Y: begin
        s_axis_tready = 1'b1;
        if (s_axis_tvalid) next = s_axis_tlast ? ISSUE : IDLE;
      end
      ISSUE: begin
        dist_req_valid = 1'b1;
        if (dist_req_ready && last_req) next = DRAIN;
      end
      DRAIN: begin
`ifdef KNN_DIST_STREAM_EN
        if (rsp_done) next = SEND_DIST;
`else
        if (rsp_done) next = SEND_D0;
`endif
      end
`ifdef KNN_DIST_STREAM_EN
      SEND_DIST: begin
        m_axis_tvalid = 1'b1;
        m_axis_tdata  = dist_buf[issue_cnt];
        if (m_axis_tready && last_req) next = SEND_D0;
      end
`endif
      SEND_D0: begin
        m_axis_tvalid = 1'b1;
        m_axis_tdata  = best_dist;
        if (m_axis_tready) next = SEND_D1;
      end
      SEND_D1: begin
        m_axis_tvalid = 1'b1;
        m_axis_tdata  = res_word;
        m_axis_tlast  = 1'b1;
        if (m_axis_tready) next = IDLE;
      end
      default: next = IDLE;
    endcase
  end

  // best_* only move during the scan, so output beats hold under stall
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      query_x    <= '0;
      query_y    <= '0;
      issue_cnt  <= '0;
      rsp_cnt    <= '0;
      best_dist  <= '0;
      best_idx   <= '0;
      best_class <= '0;
      err_frame  <= 1'b0;
`ifdef KNN_DIST_STREAM_EN
      for (int i = 0; i < NUMBER_ELEMENTS; i++) dist_buf[i] <= '0;
`endif
    end else begin
      err_frame <= 1'b0;
      if (state == IDLE && s_hs) begin
        if (s_axis_tlast) err_frame <= 1'b1;
        else              query_x   <= s_axis_tdata;
      end
      if (state == GET_Y && s_hs) begin
        if (s_axis_tlast) begin
          query_y   <= s_axis_tdata;
          issue_cnt <= '0;
          rsp_cnt   <= '0;
        end else begin
          err_frame <= 1'b1;
        end
      end
      if (state == ISSUE && req_hs)
        issue_cnt <= last_req ? '0 : issue_cnt + 1'b1;
      if (rsp_ok) begin
        rsp_cnt <= rsp_cnt + 1'b1;
        if (rsp_cnt == '0 || dist_rsp_data < best_dist) begin
          best_dist  <= dist_rsp_data;
          best_idx   <= dist_rsp_idx;
          best_class <= dist_rsp_class;
        end
`ifdef KNN_DIST_STREAM_EN
        dist_buf[dist_rsp_idx] <= dist_rsp_data;
`endif
      end
      if (state == DRAIN && rsp_done) rsp_cnt <= '0;
`ifdef KNN_DIST_STREAM_EN
      if (state == SEND_DIST && m_axis_tready)
        issue_cnt <= last_req ? '0 : issue_cnt + 1'b1;
`endif
    end
  end

endmodule

// File: tb/tb_knn_scan_ctrl.sv
// Directed bench for knn_scan_ctrl with a latency-3 squared-distance model.
module tb_knn_scan_ctrl;
  localparam int N = 6;
`ifdef KNN_DIST_STREAM_EN
  localparam int PRE = N;
`else
  localparam int PRE = 0;
`endif

  logic clk = 0, rst = 0;
  logic s_axis_tvalid = 0, s_axis_tready, s_axis_tlast = 0;
  logic [31:0] s_axis_tdata = 0;
  logic m_axis_tvalid, m_axis_tready = 1, m_axis_tlast;
  logic [31:0] m_axis_tdata, query_x, query_y;
  logic dist_req_valid, dist_req_ready;
  logic [2:0] dist_req_idx, dist_rsp_idx;
  logic dist_rsp_valid;
  logic [31:0] dist_rsp_data;
  logic [7:0] dist_rsp_class;
  logic busy, err_frame;

  knn_scan_ctrl #(.NUMBER_ELEMENTS(N), .DATA_WIDTH(32),
                  .CLASS_WIDTH(8), .IDX_WIDTH(3)) dut (
    .clk(clk), .rst(rst),
    .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready),
    .s_axis_tdata(s_axis_tdata), .s_axis_tlast(s_axis_tlast),
    .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
    .m_axis_tdata(m_axis_tdata), .m_axis_tlast(m_axis_tlast),
    .query_x(query_x), .query_y(query_y),
    .dist_req_valid(dist_req_valid), .dist_req_ready(dist_req_ready),
    .dist_req_idx(dist_req_idx),
    .dist_rsp_valid(dist_rsp_valid), .dist_rsp_idx(dist_rsp_idx),
    .dist_rsp_data(dist_rsp_data), .dist_rsp_class(dist_rsp_class),
    .busy(busy), .err_frame(err_frame));

  always #5 clk = ~clk;

  int px[0:7] = '{5100, 4900, 4700, 7000, 6400, 6900, 0, 0};
  int py[0:7] = '{3500, 3000, 3200, 3200, 3200, 3100, 0, 0};
  logic [7:0] pc[0:7] = '{0, 0, 0, 1, 1, 1, 0, 0};

  bit mode7 = 0, stall = 0;
  logic [1:0] rdy_cnt = 0;
  logic mv[3] = '{0, 0, 0};
  logic [2:0] mi[3] = '{0, 0, 0};
  int issued[8];
  int req_total = 0, beat_total = 0, err_cnt = 0, hold_err = 0;
  logic pend = 0;
  logic [2:0] pend_idx = 0;
  int n_checks = 0, n_fail = 0;
  logic [31:0] rd[16];
  logic rl[16];

  function automatic logic [31:0] sqd(input logic [2:0] i);
    longint dx, dy;
    dx = longint'(query_x) - longint'(px[i]);
    dy = longint'(query_y) - longint'(py[i]);
    return 32'(dx * dx + dy * dy);
  endfunction

  assign dist_req_ready = stall ? (rdy_cnt == 2) : 1'b1;
  assign dist_rsp_valid = mv[2];
  assign dist_rsp_idx   = mi[2];
  assign dist_rsp_class = pc[mi[2]];
  assign dist_rsp_data  = mode7 ? 32'd7 : sqd(mi[2]);

  always @(posedge clk) begin
    rdy_cnt <= (rdy_cnt == 2) ? 2'd0 : rdy_cnt + 2'd1;
    mv[0] <= dist_req_valid & dist_req_ready;
    mi[0] <= dist_req_idx;
    mv[1] <= mv[0]; mi[1] <= mi[0];
    mv[2] <= mv[1]; mi[2] <= mi[1];
    if (dist_req_valid && dist_req_ready) begin
      issued[dist_req_idx] = issued[dist_req_idx] + 1;
      req_total = req_total + 1;
    end
    if (m_axis_tvalid && m_axis_tready) beat_total = beat_total + 1;
    if (err_frame) err_cnt = err_cnt + 1;
    if (rst && pend && (!dist_req_valid || dist_req_idx != pend_idx))
      hold_err = hold_err + 1;
    pend <= dist_req_valid & ~dist_req_ready;
    pend_idx <= dist_req_idx;
  end

  task automatic send_beat(input logic [31:0] d, input logic l);
    int w;
    @(negedge clk);
    s_axis_tvalid = 1; s_axis_tdata = d; s_axis_tlast = l; w = 0;
    while (!s_axis_tready && w < 50) begin @(negedge clk); w++; end
    if (w >= 50) begin
      n_checks++; n_fail++;
      $display("FAIL send_timeout: tready never seen for %0d", d);
    end
    @(negedge clk);
    s_axis_tvalid = 0; s_axis_tlast = 0;
  endtask

  task automatic collect(input int n, input bit toggle,
                         output int cnt, output bit unstable);
    int cyc; bit held; logic [31:0] hd; logic hl;
    cnt = 0; unstable = 0; held = 0; cyc = 0; hd = 0; hl = 0;
    while (cnt < n && cyc < 300) begin
      @(negedge clk); cyc++;
      if (held && (!m_axis_tvalid || m_axis_tdata !== hd ||
                   m_axis_tlast !== hl)) unstable = 1;
      m_axis_tready = toggle ? cyc[0] : 1'b1;
      held = 0;
      if (m_axis_tvalid) begin
        if (m_axis_tready) begin
          rd[cnt] = m_axis_tdata; rl[cnt] = m_axis_tlast; cnt++;
        end else begin
          held = 1; hd = m_axis_tdata; hl = m_axis_tlast;
        end
      end
    end
    @(negedge clk);
    m_axis_tready = 1;
  endtask

  task automatic test_reset;
    rst = 0;
    repeat (2) @(negedge clk);
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy: got %0b want 0", busy); end
    n_checks++; if (m_axis_tvalid !== 1'b0) begin n_fail++; $display("FAIL rst_mvalid: got %0b want 0", m_axis_tvalid); end
    n_checks++; if (m_axis_tdata !== 32'd0) begin n_fail++; $display("FAIL rst_mdata: got %0d want 0", m_axis_tdata); end
    n_checks++; if (m_axis_tlast !== 1'b0) begin n_fail++; $display("FAIL rst_mlast: got %0b want 0", m_axis_tlast); end
    n_checks++; if (dist_req_valid !== 1'b0) begin n_fail++; $display("FAIL rst_reqv: got %0b want 0", dist_req_valid); end
    n_checks++; if (err_frame !== 1'b0) begin n_fail++; $display("FAIL rst_err: got %0b want 0", err_frame); end
    n_checks++; if (query_x !== 32'd0 || query_y !== 32'd0) begin n_fail++; $display("FAIL rst_query: got %0d/%0d want 0/0", query_x, query_y); end
    rst = 1;
    @(negedge clk);
    n_checks++; if (s_axis_tready !== 1'b1) begin n_fail++; $display("FAIL rst_sready: got %0b want 1", s_axis_tready); end
  endtask

  task automatic test_basic;
    int cnt, b0; bit un;
    b0 = beat_total;
    send_beat(5000, 0);
    n_checks++; if (query_x !== 32'd5000) begin n_fail++; $display("FAIL basic_qx: got %0d want 5000", query_x); end
    send_beat(3400, 1);
    n_checks++; if (query_y !== 32'd3400) begin n_fail++; $display("FAIL basic_qy: got %0d want 3400", query_y); end
    n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL basic_busy: got %0b want 1", busy); end
    collect(PRE + 2, 0, cnt, un);
    n_checks++; if (cnt !== PRE + 2) begin n_fail++; $display("FAIL basic_cnt: got %0d want %0d", cnt, PRE + 2); end
    n_checks++; if (rd[PRE] !== 32'd20000 || rl[PRE] !== 1'b0) begin n_fail++; $display("FAIL basic_d0: got %0d/%0b want 20000/0", rd[PRE], rl[PRE]); end
    n_checks++; if (rd[PRE+1] !== 32'd0 || rl[PRE+1] !== 1'b1) begin n_fail++; $display("FAIL basic_d1: got %0h/%0b want 0/1", rd[PRE+1], rl[PRE+1]); end
    repeat (3) @(negedge clk);
    n_checks++; if (beat_total - b0 !== PRE + 2) begin n_fail++; $display("FAIL basic_beats: got %0d want %0d", beat_total - b0, PRE + 2); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL basic_idle: got %0b want 0", busy); end
  endtask

  task automatic test_backpressure;
    int cnt; bit un;
    send_beat(6800, 0);
    send_beat(3150, 1);
    collect(PRE + 2, 1, cnt, un);
    n_checks++; if (rd[PRE] !== 32'd12500) begin n_fail++; $display("FAIL bp_d0: got %0d want 12500", rd[PRE]); end
    n_checks++; if (rd[PRE+1] !== 32'h501 || rl[PRE+1] !== 1'b1) begin n_fail++; $display("FAIL bp_d1: got %0h/%0b want 501/1", rd[PRE+1], rl[PRE+1]); end
    n_checks++; if (un !== 1'b0) begin n_fail++; $display("FAIL bp_stable: got %0b want 0", un); end
  endtask

  task automatic test_req_stall;
    int cnt, h0; bit un;
    for (int i = 0; i < 8; i++) issued[i] = 0;
    mode7 = 1; stall = 1; h0 = hold_err;
    send_beat(5000, 0);
    send_beat(3400, 1);
    collect(PRE + 2, 0, cnt, un);
    n_checks++; if (rd[PRE] !== 32'd7) begin n_fail++; $display("FAIL stall_d0: got %0d want 7", rd[PRE]); end
    n_checks++; if (rd[PRE+1] !== 32'd0) begin n_fail++; $display("FAIL stall_d1: got %0h want 0", rd[PRE+1]); end
    for (int i = 0; i < N; i++) begin
      n_checks++; if (issued[i] !== 1) begin n_fail++; $display("FAIL stall_issue%0d: got %0d want 1", i, issued[i]); end
    end
    n_checks++; if (hold_err - h0 !== 0) begin n_fail++; $display("FAIL stall_hold: got %0d want 0", hold_err - h0); end
    mode7 = 0; stall = 0;
  endtask

  task automatic test_frame_err;
    int cnt, b0, e0; bit un;
    b0 = beat_total; e0 = err_cnt;
    send_beat(1234, 1);
    repeat (4) @(negedge clk);
    n_checks++; if (err_cnt - e0 !== 1) begin n_fail++; $display("FAIL ferr_pulse: got %0d want 1", err_cnt - e0); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL ferr_idle: got %0b want 0", busy); end
    n_checks++; if (beat_total - b0 !== 0) begin n_fail++; $display("FAIL ferr_nobeat: got %0d want 0", beat_total - b0); end
    send_beat(111, 0);
    send_beat(222, 0);
    repeat (2) @(negedge clk);
    n_checks++; if (err_cnt - e0 !== 2 || busy !== 1'b0) begin n_fail++; $display("FAIL ferr_gety: got %0d/%0b want 2/0", err_cnt - e0, busy); end
    send_beat(5000, 0);
    send_beat(3400, 1);
    collect(PRE + 2, 0, cnt, un);
    n_checks++; if (rd[PRE] !== 32'd20000 || rd[PRE+1] !== 32'd0) begin n_fail++; $display("FAIL ferr_res: got %0d/%0h want 20000/0", rd[PRE], rd[PRE+1]); end
  endtask

  task automatic test_reset_mid;
    int cnt, b0, r0, w; bit un;
    r0 = req_total; w = 0;
    send_beat(5000, 0);
    send_beat(3400, 1);
    while (req_total < r0 + N && w < 200) begin @(negedge clk); w++; end
    n_checks++; if (req_total - r0 !== N) begin n_fail++; $display("FAIL rmid_reqs: got %0d want %0d", req_total - r0, N); end
    b0 = beat_total;
    rst = 0;
    #1;
    n_checks++; if (busy !== 1'b0 || m_axis_tvalid !== 1'b0) begin n_fail++; $display("FAIL rmid_abort: got %0b/%0b want 0/0", busy, m_axis_tvalid); end
    repeat (2) @(negedge clk);
    rst = 1;
    repeat (5) @(negedge clk);
    n_checks++; if (beat_total - b0 !== 0) begin n_fail++; $display("FAIL rmid_stale: got %0d want 0", beat_total - b0); end
    send_beat(6800, 0);
    send_beat(3150, 1);
    collect(PRE + 2, 0, cnt, un);
    n_checks++; if (rd[PRE] !== 32'd12500 || rd[PRE+1] !== 32'h501) begin n_fail++; $display("FAIL rmid_res: got %0d/%0h want 12500/501", rd[PRE], rd[PRE+1]); end
    n_checks++; if (beat_total - b0 !== PRE + 2) begin n_fail++; $display("FAIL rmid_beats: got %0d want %0d", beat_total - b0, PRE + 2); end
  endtask

`ifdef KNN_DIST_STREAM_EN
  task automatic test_stream;
    int cnt; bit un;
    logic [31:0] exp_d[8];
    exp_d = '{20000, 170000, 130000, 4040000, 2000000, 3700000, 20000, 0};
    send_beat(5000, 0);
    send_beat(3400, 1);
    collect(N + 2, 0, cnt, un);
    for (int i = 0; i < N + 2; i++) begin
      n_checks++; if (rd[i] !== exp_d[i] || rl[i] !== (i == N + 1)) begin n_fail++; $display("FAIL stream_b%0d: got %0d/%0b want %0d/%0b", i, rd[i], rl[i], exp_d[i], i == N + 1); end
    end
  endtask
`endif

  initial begin
    for (int i = 0; i < 8; i++) issued[i] = 0;
    test_reset;
    test_basic;
    test_backpressure;
    test_req_stall;
    test_frame_err;
    test_reset_mid;
`ifdef KNN_DIST_STREAM_EN
    test_stream;
`endif
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
